// File: rtl/rv_mem_sys.sv
// Single-port word memory with a three-state request FSM, a completion mailbox
// and a cycle-counting watchdog for simulation-driven CPU test benches.
module rv_mem_sys #(
  parameter int                 DPWIDTH     = 32,
  parameter int                 LOGMEM_SIZE = 10,
  parameter int                 WAIT_STATES = 0,
  parameter int                 TIMEOUT     = 10000,
  parameter logic [DPWIDTH-1:0] DONE_ADDR   = 32'hFFFF,
  parameter logic [DPWIDTH-1:0] DONE_DATA   = 32'hDEAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [DPWIDTH-1:0]   addr,
  input  logic [DPWIDTH/8-1:0] be,
  input  logic [DPWIDTH-1:0]   wdata,
  output logic [DPWIDTH-1:0]   rdata,
  output logic                 ready,
  output logic                 err,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          cycle_cnt
);

  localparam int                 BYTES     = DPWIDTH / 8;
  localparam int                 OFFW      = $clog2(BYTES);
  localparam int                 MEM_DEPTH = 1 << LOGMEM_SIZE;
  localparam logic [DPWIDTH-1:0] OFF_MASK  = DPWIDTH'(BYTES - 1);
  localparam logic [3:0]         WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0]        TO_LIMIT  = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_wait_cnt;
  logic                 r_we;
  logic [DPWIDTH-1:0]   r_addr;
  logic [BYTES-1:0]     r_be;
  logic [DPWIDTH-1:0]   r_wdata;
  logic                 r_done;
  logic                 r_timeout;
  logic [31:0]          r_cycle_cnt;

  logic [DPWIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                 w_accept;
  logic                 w_resp;
  logic                 w_is_done_addr;
  logic                 w_misaligned;
  logic                 w_out_of_range;
  logic                 w_mem_ok;
  logic                 w_done_hit;
  logic                 w_set_done;
  logic                 w_cnt_run;
  logic [31:0]          w_cnt_next;
  logic [LOGMEM_SIZE-1:0] w_idx;

  // Decode works on the latched request so inputs may change freely after acceptance.
  assign w_accept       = (r_state == IDLE) && req;
  assign w_resp         = (r_state == RESP);
  assign w_is_done_addr = (r_addr == DONE_ADDR);
  assign w_misaligned   = |(r_addr & OFF_MASK);
  assign w_out_of_range = (r_addr >> (LOGMEM_SIZE + OFFW)) != '0;
  assign w_mem_ok       = !w_is_done_addr && !w_misaligned && !w_out_of_range;
  assign w_idx          = r_addr[LOGMEM_SIZE+OFFW-1:OFFW];
  assign w_done_hit     = w_is_done_addr && r_we && (r_wdata == DONE_DATA) && (&r_be);
  assign w_set_done     = w_resp && w_done_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we       <= we;
        r_addr     <= addr;
        r_be       <= be;
        r_wdata    <= wdata;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    err          = 1'b0;
    rdata        = '0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
        ready        = 1'b1;
        err          = !w_is_done_addr && (w_misaligned || w_out_of_range);
        if (w_mem_ok && !r_we) begin
          rdata = r_mem[w_idx];
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // NOTE: the storage array has no reset; the state register is forced to IDLE
  // by reset, which alone keeps an aborted write from reaching memory.
  always_ff @(posedge clk) begin
    if (w_resp && w_mem_ok && r_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Counter freezes on either sticky flag and saturates instead of wrapping.
  assign w_cnt_run  = !r_done && !r_timeout;
  assign w_cnt_next = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= 32'd0;
    end else begin
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_cnt_run) begin
        r_cycle_cnt <= w_cnt_next;
        // A completion landing on the same edge takes precedence over the watchdog.
        if (!w_set_done && (w_cnt_next >= TO_LIMIT)) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_rv_mem_sys.sv
// Randomized and directed checks of rv_mem_sys against a word/byte-level model,
// using three instances with different latency and watchdog settings.
module tb_rv_mem_sys;

  localparam logic [31:0] DONE_A = 32'hFFFF;
  localparam logic [31:0] DONE_D = 32'hDEAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_s;
  logic [2:0]        req_s;
  logic [2:0]        we_s;
  logic [2:0][31:0]  addr_s;
  logic [2:0][3:0]   be_s;
  logic [2:0][31:0]  wdata_s;
  logic [2:0][31:0]  rdata_o;
  logic [2:0]        ready_o;
  logic [2:0]        err_o;
  logic [2:0]        done_o;
  logic [2:0]        timeout_o;
  logic [2:0][31:0]  cnt_o;

  rv_mem_sys #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .be(be_s[0]), .wdata(wdata_s[0]), .rdata(rdata_o[0]), .ready(ready_o[0]),
    .err(err_o[0]), .done(done_o[0]), .timeout(timeout_o[0]), .cycle_cnt(cnt_o[0])
  );

  rv_mem_sys #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .be(be_s[1]), .wdata(wdata_s[1]), .rdata(rdata_o[1]), .ready(ready_o[1]),
    .err(err_o[1]), .done(done_o[1]), .timeout(timeout_o[1]), .cycle_cnt(cnt_o[1])
  );

  rv_mem_sys #(.WAIT_STATES(1), .TIMEOUT(50)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .be(be_s[2]), .wdata(wdata_s[2]), .rdata(rdata_o[2]), .ready(ready_o[2]),
    .err(err_o[2]), .done(done_o[2]), .timeout(timeout_o[2]), .cycle_cnt(cnt_o[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-instance word store plus "fully known" flags.
  bit [31:0] mdl   [3][1024];
  bit        known [3][1024];
  bit        exp_done [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic void model_op(input int d, input bit w, input logic [31:0] a,
                                   input logic [3:0] b, input logic [31:0] wd,
                                   output bit e, output bit rd_valid, output logic [31:0] rd);
    int idx;
    e = 1'b0;
    rd_valid = 1'b0;
    rd = 32'd0;
    if (a == DONE_A) begin
      rd_valid = !w;
      if (w && wd == DONE_D && b == 4'hF) exp_done[d] = 1'b1;
    end else if ((a % 4) != 0 || a >= 32'h1000) begin
      e = 1'b1;
      rd_valid = 1'b1;
    end else begin
      idx = int'(a / 4);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
        if (b == 4'hF) known[d][idx] = 1'b1;
      end else begin
        rd_valid = known[d][idx];
        rd = mdl[d][idx];
      end
    end
  endfunction

  // One bus transaction; checks request-to-ready latency and single-cycle pulse.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input bit hold,
                     output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; be_s[d] = b; wdata_s[d] = wd;
    lat = -1;
    rd = 32'd0;
    e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!hold) begin
        req_s[d] = 1'b0;
        addr_s[d] = $urandom;
        wdata_s[d] = $urandom;
        be_s[d] = 4'($urandom);
      end
      if (ready_o[d]) begin
        rd = rdata_o[d];
        e = err_o[d];
        lat = i;
        break;
      end
    end
    req_s[d] = 1'b0;
    check($sformatf("latency d%0d a%h", d, a), 32'(lat), 32'(ws_of(d) + 1));
    @(negedge clk);
    check($sformatf("pulse width d%0d", d), 32'(ready_o[d]), 32'd0);
  endtask

  task automatic do_op(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, output logic [31:0] rd);
    logic e;
    int lat;
    bit exp_e, rv;
    logic [31:0] exp_rd;
    txn(d, w, a, b, wd, 1'b0, rd, e, lat);
    model_op(d, w, a, b, wd, exp_e, rv, exp_rd);
    check($sformatf("err d%0d a%h w%0d", d, a, w), 32'(e), 32'(exp_e));
    if (rv) check($sformatf("rdata d%0d a%h", d, a), rd, exp_rd);
    check($sformatf("done d%0d", d), 32'(done_o[d]), 32'(exp_done[d]));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 31)) << 2;
      6:                return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      7:                return 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
      8:                return DONE_A;
      default:          return $urandom;
    endcase
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          seen;
    logic [31:0] c0;

    rst_s = '0; req_s = '0; we_s = '0; addr_s = '0; be_s = '0; wdata_s = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d += 2) begin
      check($sformatf("rst ready d%0d", d), 32'(ready_o[d]), 32'd0);
      check($sformatf("rst err d%0d", d), 32'(err_o[d]), 32'd0);
      check($sformatf("rst rdata d%0d", d), rdata_o[d], 32'd0);
      check($sformatf("rst done d%0d", d), 32'(done_o[d]), 32'd0);
      check($sformatf("rst timeout d%0d", d), 32'(timeout_o[d]), 32'd0);
      check($sformatf("rst cnt d%0d", d), cnt_o[d], 32'd0);
    end

    // Release all instances together; after k rising edges cycle_cnt must read k.
    rst_s = '1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("cnt5 d0", cnt_o[0], 32'd5);
        check("cnt5 d2", cnt_o[2], 32'd5);
      end
      if (k == 49) begin
        check("timeout49", 32'(timeout_o[2]), 32'd0);
        check("cnt49", cnt_o[2], 32'd49);
      end
      if (k == 50) begin
        check("timeout50", 32'(timeout_o[2]), 32'd1);
        check("cnt50", cnt_o[2], 32'd50);
      end
    end
    check("timeout sticky", 32'(timeout_o[2]), 32'd1);
    check("cnt frozen on timeout", cnt_o[2], 32'd50);
    check("cnt60 d0", cnt_o[0], 32'd60);
    check("no timeout d0", 32'(timeout_o[0]), 32'd0);

    // Service continues after the watchdog fires.
    do_op(2, 1'b1, 32'h8, 4'hF, 32'h0BADCAFE, rd);
    do_op(2, 1'b0, 32'h8, 4'hF, 32'h0, rd);
    check("after timeout read", rd, 32'h0BADCAFE);

    do_op(0, 1'b1, 32'h10, 4'hF, 32'h12345678, rd);
    do_op(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    check("basic read", rd, 32'h12345678);

    do_op(0, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, rd);
    do_op(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, rd);
    do_op(0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
    check("byte enables", rd, 32'hAA22CC44);

    do_op(0, 1'b1, 32'h0, 4'hF, 32'h01020304, rd);
    do_op(0, 1'b0, 32'h2, 4'hF, 32'h0, rd);
    do_op(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd);
    do_op(0, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF, rd);
    do_op(0, 1'b0, 32'h0, 4'hF, 32'h0, rd);
    check("out of range no alias", rd, 32'h01020304);
    do_op(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    check("misaligned no write", rd, 32'h12345678);

    do_op(0, 1'b0, DONE_A, 4'hF, 32'h0, rd);
    do_op(0, 1'b1, DONE_A, 4'h7, DONE_D, rd);
    do_op(0, 1'b1, DONE_A, 4'hF, 32'hBEEF, rd);

    // Request held high through WAIT must not start a second transaction.
    do_op(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd);
    txn(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, rd, e, lat);
    check("hold rdata", rd, 32'hCAFEF00D);
    check("hold err", 32'(e), 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready_o[1]) seen++;
    end
    check("hold no second txn", 32'(seen), 32'd0);

    // Reset during WAIT of a write aborts it.
    do_op(1, 1'b1, 32'h40, 4'hF, 32'h55AA55AA, rd);
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h40; be_s[1] = 4'hF; wdata_s[1] = 32'h12345678;
    @(negedge clk);
    req_s[1] = 1'b0;
    @(negedge clk);
    #2 rst_s[1] = 1'b0;
    #1;
    check("midrst ready", 32'(ready_o[1]), 32'd0);
    check("midrst err", 32'(err_o[1]), 32'd0);
    check("midrst rdata", rdata_o[1], 32'd0);
    check("midrst done", 32'(done_o[1]), 32'd0);
    check("midrst timeout", 32'(timeout_o[1]), 32'd0);
    check("midrst cnt", cnt_o[1], 32'd0);
    seen = 0;
    @(negedge clk);
    if (ready_o[1]) seen++;
    @(negedge clk);
    if (ready_o[1]) seen++;
    rst_s[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready_o[1]) seen++;
    end
    check("midrst no ready", 32'(seen), 32'd0);
    check("cnt after rst", cnt_o[1], 32'd8);
    do_op(1, 1'b0, 32'h40, 4'hF, 32'h0, rd);
    check("midrst word kept", rd, 32'h55AA55AA);

    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 2; d++) begin
        do_op(d, 1'($urandom), rand_addr(), 4'($urandom), $urandom, rd);
      end
    end

    // Completion mailbox: done sets, counter freezes, service continues.
    do_op(0, 1'b1, DONE_A, 4'hF, DONE_D, rd);
    check("done set", 32'(done_o[0]), 32'd1);
    c0 = cnt_o[0];
    repeat (5) @(negedge clk);
    check("cnt frozen on done", cnt_o[0], c0);
    check("done no timeout", 32'(timeout_o[0]), 32'd0);
    do_op(0, 1'b1, 32'h10, 4'hF, 32'h87654321, rd);
    do_op(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    check("after done read", rd, 32'h87654321);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
